match_scorer: RTL and testbench

Multi-round successor to the single-round tug-of-war winner latch. It detects a round win when a player presses while their edge light is lit, and keeps a per-player round score. After each round it shows the round winner for a hold time, then pulses a reset to the playfield. The match ends and latches when either player reaches WIN_ROUNDS. It sits between the playfield LED chain and the HEX displays.

---
 rtl/match_scorer.sv | 121 ++++++++++++
 tb/tb_match_scorer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/match_scorer.sv
// Multi-round tug-of-war match scorer: detects round wins at the playfield edges,
// keeps per-player scores, holds the round winner, restarts the playfield, latches the match result.
module match_scorer #(
  parameter int         WIN_ROUNDS = 3,
  parameter int         DISP_HOLD  = 50000000,
  parameter logic [6:0] OFF        = 7'b1111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       NL,
  input  logic       NR,
  output logic       round_reset,
  output logic [6:0] disp_p1,
  output logic [6:0] disp_p2,
  output logic [6:0] disp_win,
  output logic       match_over
);

  localparam int            CW         = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(DISP_HOLD - 1);
  localparam logic [3:0]    WIN_SCORE  = 4'(WIN_ROUNDS);

  localparam logic [1:0] PLAY       = 2'd0;
  localparam logic [1:0] HOLD       = 2'd1;
  localparam logic [1:0] RESTART    = 2'd2;
  localparam logic [1:0] MATCH_OVER = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_p1_score;
  logic [3:0]    r_p2_score;
  logic [CW-1:0] r_hold_cnt;
  logic          r_winner;     // 0 = P1, 1 = P2

  logic       w_p1_hit;
  logic       w_p2_hit;
  logic [3:0] w_p1_next;
  logic [3:0] w_p2_next;

  assign w_p1_hit  = L & NL;
  assign w_p2_hit  = R & NR;
  assign w_p1_next = r_p1_score + 4'd1;
  assign w_p2_next = r_p2_score + 4'd1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = OFF;
    endcase
  endfunction

  // NOTE: reset is sampled inside the clocked block (synchronous), and all state uses <= so
  // every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PLAY;
      r_p1_score <= 4'd0;
      r_p2_score <= 4'd0;
      r_hold_cnt <= '0;
      r_winner   <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          // P1 wins ties: only one player can score per cycle.
          if (w_p1_hit) begin
            r_p1_score <= w_p1_next;
            r_winner   <= 1'b0;
            if (w_p1_next == WIN_SCORE) begin
              r_state <= MATCH_OVER;
            end else begin
              r_state    <= HOLD;
              r_hold_cnt <= HOLD_LOAD;
            end
          end else if (w_p2_hit) begin
            r_p2_score <= w_p2_next;
            r_winner   <= 1'b1;
            if (w_p2_next == WIN_SCORE) begin
              r_state <= MATCH_OVER;
            end else begin
              r_state    <= HOLD;
              r_hold_cnt <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state <= RESTART;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        RESTART: r_state <= PLAY;
        default: r_state <= MATCH_OVER;
      endcase
    end
  end

  assign round_reset = (r_state == RESTART);
  assign match_over  = (r_state == MATCH_OVER);
  assign disp_p1     = seg7(r_p1_score);
  assign disp_p2     = seg7(r_p2_score);

  // NOTE: default first so every path assigns disp_win and no latch is inferred.
  always_comb begin
    disp_win = OFF;
    if (r_state == HOLD || r_state == MATCH_OVER) begin
      disp_win = r_winner ? 7'b0100100 : 7'b1111001;
    end
  end

endmodule

// File: tb/tb_match_scorer.sv
// Scoreboard bench for match_scorer: stimulus queues cycle-stamped expected outputs,
// a monitor pops and compares them and flags any output change nobody predicted.
module tb_match_scorer;

  localparam int         WR  = 3;
  localparam int         DH  = 4;
  localparam logic [6:0] D0  = 7'b1000000;
  localparam logic [6:0] D1  = 7'b1111001;
  localparam logic [6:0] D2  = 7'b0100100;
  localparam logic [6:0] D3  = 7'b0110000;
  localparam logic [6:0] OFF = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       L = 1'b0, R = 1'b0, NL = 1'b0, NR = 1'b0;
  logic       round_reset, match_over;
  logic [6:0] disp_p1, disp_p2, disp_win;

  match_scorer #(.WIN_ROUNDS(WR), .DISP_HOLD(DH), .OFF(OFF)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .NL(NL), .NR(NR),
    .round_reset(round_reset), .disp_p1(disp_p1), .disp_p2(disp_p2),
    .disp_win(disp_win), .match_over(match_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: parallel queues of cycle stamp, check name and {rr, mo, p1, p2, win}.
  int          exp_cyc[$];
  string       exp_name[$];
  logic [22:0] exp_v[$];
  int          total = 0;
  int          bad = 0;

  task automatic expect_at(input int c, input string n, input logic rr, input logic mo,
                           input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] w);
    exp_cyc.push_back(c);
    exp_name.push_back(n);
    exp_v.push_back({rr, mo, p1, p2, w});
  endtask

  task automatic expect_span(input int c0, input int c1, input string n, input logic rr,
                             input logic mo, input logic [6:0] p1, input logic [6:0] p2,
                             input logic [6:0] w);
    for (int c = c0; c <= c1; c++) expect_at(c, n, rr, mo, p1, p2, w);
  endtask

  // Drives one cycle of inputs; k is the monitor stamp at which the sampled edge shows up.
  task automatic drive(input logic l, input logic r, input logic nl, input logic nr,
                       output int k);
    @(posedge clk); #1;
    L = l; R = r; NL = nl; NR = nr;
    k = cyc + 1;
    @(posedge clk); #1;
    L = 1'b0; R = 1'b0; NL = 1'b0; NR = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor
  initial begin : monitor
    logic [22:0] cur;
    logic [22:0] prev;
    logic [22:0] v;
    string       n;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {round_reset, match_over, disp_p1, disp_p2, disp_win};
      while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
        total++; bad++;
        $display("FAIL %s: stamp %0d passed unchecked at cycle %0d", exp_name[0], exp_cyc[0], cyc);
        void'(exp_cyc.pop_front()); void'(exp_name.pop_front()); void'(exp_v.pop_front());
      end
      if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
        v = exp_v.pop_front();
        n = exp_name.pop_front();
        void'(exp_cyc.pop_front());
        total++;
        if (cur !== v) begin
          bad++;
          $display("FAIL %s @%0d: got rr=%b mo=%b p1=%b p2=%b win=%b, want rr=%b mo=%b p1=%b p2=%b win=%b",
                   n, cyc, cur[22], cur[21], cur[20:14], cur[13:7], cur[6:0],
                   v[22], v[21], v[20:14], v[13:7], v[6:0]);
        end
      end else if (cur !== prev) begin
        total++; bad++;
        $display("FAIL unexpected_change @%0d: got rr=%b mo=%b p1=%b p2=%b win=%b, was rr=%b mo=%b p1=%b p2=%b win=%b",
                 cyc, cur[22], cur[21], cur[20:14], cur[13:7], cur[6:0],
                 prev[22], prev[21], prev[20:14], prev[13:7], prev[6:0]);
      end
      prev = cur;
    end
  end

  // Stimulus
  initial begin : stim
    int k;
    int kx;
    int a, b, c, d;

    // Reset and idle
    expect_at(1, "reset", 1'b0, 1'b0, D0, D0, OFF);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    expect_at(cyc, "idle", 1'b0, 1'b0, D0, D0, OFF);

    // P1 round win, full HOLD/RESTART timing, press during HOLD ignored
    drive(1'b1, 1'b0, 1'b1, 1'b0, k);
    expect_span(k, k + 3, "p1_round_hold", 1'b0, 1'b0, D1, D0, D1);
    expect_at(k + 4, "p1_restart", 1'b1, 1'b0, D1, D0, OFF);
    expect_at(k + 5, "p1_back_to_play", 1'b0, 1'b0, D1, D0, OFF);
    drive(1'b1, 1'b0, 1'b1, 1'b0, kx);
    wait_until(k + 5);

    // Simultaneous hits: P1 priority
    drive(1'b1, 1'b1, 1'b1, 1'b1, k);
    expect_at(k, "both_hit_p1_wins", 1'b0, 1'b0, D2, D0, D1);
    expect_at(k + 4, "both_restart", 1'b1, 1'b0, D2, D0, OFF);
    expect_at(k + 5, "both_back_to_play", 1'b0, 1'b0, D2, D0, OFF);
    wait_until(k + 5);

    // Presses without lights, lights without presses
    drive(1'b1, 1'b0, 1'b0, 1'b0, k);
    expect_at(k, "l_without_nl", 1'b0, 1'b0, D2, D0, OFF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, k);
    expect_at(k, "r_without_nr", 1'b0, 1'b0, D2, D0, OFF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, k);
    expect_at(k, "lights_only", 1'b0, 1'b0, D2, D0, OFF);
    expect_span(k + 1, k + 5, "no_restart", 1'b0, 1'b0, D2, D0, OFF);
    wait_until(k + 5);

    // Reset mid-HOLD at 2-1
    drive(1'b0, 1'b1, 1'b0, 1'b1, k);
    expect_at(k, "p2_round_2_1", 1'b0, 1'b0, D2, D1, D2);
    expect_at(k + 1, "hold_before_reset", 1'b0, 1'b0, D2, D1, D2);
    expect_span(k + 2, k + 7, "reset_mid_hold", 1'b0, 1'b0, D0, D0, OFF);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_until(k + 7);

    // P2 takes the match 3-1
    drive(1'b0, 1'b1, 1'b0, 1'b1, a);
    expect_at(a, "m_p2_r1", 1'b0, 1'b0, D0, D1, D2);
    expect_at(a + 4, "m_restart1", 1'b1, 1'b0, D0, D1, OFF);
    expect_at(a + 5, "m_play1", 1'b0, 1'b0, D0, D1, OFF);
    wait_until(a + 5);
    drive(1'b1, 1'b0, 1'b1, 1'b0, b);
    expect_at(b, "m_p1_r2", 1'b0, 1'b0, D1, D1, D1);
    expect_at(b + 4, "m_restart2", 1'b1, 1'b0, D1, D1, OFF);
    expect_at(b + 5, "m_play2", 1'b0, 1'b0, D1, D1, OFF);
    wait_until(b + 5);
    drive(1'b0, 1'b1, 1'b0, 1'b1, c);
    expect_at(c, "m_p2_r3", 1'b0, 1'b0, D1, D2, D2);
    expect_at(c + 4, "m_restart3", 1'b1, 1'b0, D1, D2, OFF);
    expect_at(c + 5, "m_play3", 1'b0, 1'b0, D1, D2, OFF);
    wait_until(c + 5);
    drive(1'b0, 1'b1, 1'b0, 1'b1, d);
    expect_span(d, d + 12, "match_over_p2", 1'b0, 1'b1, D1, D3, D2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, kx);
    drive(1'b0, 1'b1, 1'b0, 1'b1, kx);
    drive(1'b1, 1'b1, 1'b1, 1'b1, kx);
    wait_until(d + 12);
    repeat (2) @(posedge clk);
    #1;

    while (exp_cyc.size() > 0) begin
      total++; bad++;
      $display("FAIL %s: stamp %0d never reached", exp_name[0], exp_cyc[0]);
      void'(exp_cyc.pop_front()); void'(exp_name.pop_front()); void'(exp_v.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
